// File: rtl/polar_frame_rx.sv
// polar_frame_rx
// ---------------------------------------------------------------------------
// Double-buffered polar frame store for the spinning display.
//
// The Cartesian-to-polar converter writes each frame through the AXI-Lite
// write channels into the back bank. Meanwhile the front bank is streamed to
// the LED arm driver, one angle slice of WPA words per angle_tick. A back bank
// that has received its final word is swapped to the front when the angle
// counter wraps to 0.
//
// Ports
//   clock, resetn             : clock, synchronous active-low reset
//   s_axi_aw* / s_axi_w*      : write address / data (independent one-deep holds)
//   s_axi_b*                  : write response (OKAY or SLVERR)
//   s_axi_ar* / s_axi_r*      : status read (address ignored)
//   angle_tick                : one-cycle pulse, start next angle slice
//   led_data/valid/ready/last : LED word stream, led_last on the slice's final word
//
// Handshake rule for every channel: a transfer happens in the cycle where
// valid and ready are both high. Once raised, a valid stays high and its
// payload stays stable until that transfer.
//
// Optional feature macro: POLAR_RX_ERR_CNT_EN
//   defined   -> 8-bit saturating SLVERR counter, reported in status[31:24]
//   undefined -> no counter, status[31:24] reads 0
// ---------------------------------------------------------------------------
module polar_frame_rx #(
   parameter int NO_ARM_LED         = 32,
   parameter int NO_DELTA_INTERVALS = 18,
   parameter int RGB_SIZE           = 8,
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 32,
   parameter int BANK_OFF           = 16000
) (
   input  logic                    clock,
   input  logic                    resetn,
   // write address channel
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   // write data channel
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   // write response channel
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   // read address channel
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   // read data channel
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   // LED stream
   input  logic                    angle_tick,
   output logic [DATA_WIDTH-1:0]   led_data,
   output logic                    led_valid,
   input  logic                    led_ready,
   output logic                    led_last
);

   localparam int WPA    = NO_ARM_LED * RGB_SIZE / DATA_WIDTH;
   localparam int WORDS  = NO_DELTA_INTERVALS * WPA;
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(WORDS);
   localparam int MEM_W  = $clog2(2 * WORDS);
   localparam int ANG_W  = $clog2(NO_DELTA_INTERVALS);
   localparam int WRD_W  = (WPA > 1) ? $clog2(WPA) : 1;

   localparam logic [ADDR_WIDTH-1:0] BANK_BYTES = ADDR_WIDTH'(WORDS * 4);
   localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(BANK_OFF);
   localparam logic [ADDR_WIDTH-1:0] BANK1_END  = ADDR_WIDTH'(BANK_OFF + WORDS * 4);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic                  aw_held_q,   aw_held_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q,   aw_addr_d;
   logic                  w_held_q,    w_held_d;
   logic [DATA_WIDTH-1:0] w_data_q,    w_data_d;
   logic [STRB_W-1:0]     w_strb_q,    w_strb_d;
   logic                  bvalid_q,    bvalid_d;
   logic [1:0]            bresp_q,     bresp_d;
   logic                  rvalid_q,    rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
   logic                  front_q,     front_d;
   logic                  back_full_q, back_full_d;
   logic                  overrun_q,   overrun_d;
   logic [ANG_W-1:0]      angle_q,     angle_d;
   logic                  led_valid_q, led_valid_d;
   logic [WRD_W-1:0]      word_q,      word_d;

   // Frame store: bank 0 at [0, WORDS), bank 1 at [WORDS, 2*WORDS). Not reset.
   logic [DATA_WIDTH-1:0] mem_q [2*WORDS];

   logic [7:0] err_cnt;

   // ------------------------------------------------------------------------
   // Write capture and decode
   // ------------------------------------------------------------------------
   logic                  aw_hs, w_hs, ar_hs;
   logic                  aw_have, w_have, wr_fire;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;
   logic                  in_b0, in_b1, wr_bank, wr_ok;
   logic [ADDR_WIDTH-1:0] wr_off;
   logic [IDX_W-1:0]      wr_idx;
   logic [MEM_W-1:0]      wr_mem_addr;
   logic                  wr_last_word;

   assign s_axi_awready = ~aw_held_q & ~bvalid_q;
   assign s_axi_wready  = ~w_held_q & ~bvalid_q;
   assign s_axi_arready = ~rvalid_q;

   assign aw_hs = s_axi_awvalid & s_axi_awready;
   assign w_hs  = s_axi_wvalid & s_axi_wready;
   assign ar_hs = s_axi_arvalid & s_axi_arready;

   // A channel counts as present if it is already held or is handshaking
   // this cycle, so the write completes at the same edge the second half
   // arrives and bvalid is visible the following cycle.
   assign aw_have = aw_held_q | aw_hs;
   assign w_have  = w_held_q | w_hs;
   assign wr_fire = aw_have & w_have;

   assign wr_addr = aw_held_q ? aw_addr_q : s_axi_awaddr;
   assign wr_data = w_held_q ? w_data_q : s_axi_wdata;
   assign wr_strb = w_held_q ? w_strb_q : s_axi_wstrb;

   always_comb begin
      in_b0        = (wr_addr < BANK_BYTES);
      in_b1        = (wr_addr >= BANK1_BASE) && (wr_addr < BANK1_END);
      // Bank 0 takes priority should the two windows ever overlap.
      wr_bank      = ~in_b0;
      wr_off       = in_b0 ? wr_addr : (wr_addr - BANK1_BASE);
      wr_idx       = wr_off[IDX_W+1:2];
      wr_ok        = (in_b0 | in_b1) && (wr_addr[1:0] == 2'b00) && (wr_bank != front_q);
      wr_mem_addr  = MEM_W'(int'(wr_idx) + (wr_bank ? WORDS : 0));
      wr_last_word = (wr_idx == IDX_W'(WORDS - 1));
   end

   always_comb begin
      aw_held_d = aw_held_q;
      aw_addr_d = aw_addr_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_addr_d = s_axi_awaddr;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end
      // Readies are low while bvalid is up, so a new write can never
      // complete in the same cycle the previous response is still pending.
      if (wr_fire) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (resetn && wr_fire && wr_ok) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
               mem_q[wr_mem_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Rotation, bank swap and slice streaming
   // ------------------------------------------------------------------------
   logic [ANG_W-1:0] angle_nxt;
   logic             swap;
   logic             word_is_last;
   logic             ovr_set;

   assign word_is_last = (word_q == WRD_W'(WPA - 1));

   always_comb begin
      angle_nxt = (angle_q == ANG_W'(NO_DELTA_INTERVALS - 1)) ? '0 : angle_q + 1'b1;
      swap      = angle_tick && (angle_nxt == '0) && back_full_q;

      angle_d     = angle_q;
      front_d     = front_q;
      back_full_d = back_full_q;
      led_valid_d = led_valid_q;
      word_d      = word_q;
      ovr_set     = 1'b0;

      if (wr_fire && wr_ok && wr_last_word) begin
         back_full_d = 1'b1;
      end

      if (angle_tick) begin
         angle_d = angle_nxt;
         // The swapping bank must arrive empty, so the swap clear wins over
         // a same-cycle final-word write into the outgoing back bank.
         if (swap) begin
            front_d     = ~front_q;
            back_full_d = 1'b0;
         end
         // A tick that lands on the final word's handshake aborts nothing.
         ovr_set     = led_valid_q & ~(led_ready & word_is_last);
         led_valid_d = 1'b1;
         word_d      = '0;
      end else if (led_valid_q && led_ready) begin
         if (word_is_last) begin
            led_valid_d = 1'b0;
         end else begin
            word_d = word_q + 1'b1;
         end
      end

      overrun_d = overrun_q;
      if (rvalid_q && s_axi_rready) begin
         overrun_d = 1'b0;
      end
      if (ovr_set) begin
         overrun_d = 1'b1;
      end
   end

   // The read index follows the registered front/angle/word, so a swap at
   // tick T shows up on the word presented at T+1.
   logic [MEM_W-1:0] rd_addr;

   always_comb begin
      rd_addr = MEM_W'(int'(angle_q) * WPA + int'(word_q) + (front_q ? WORDS : 0));
   end

   assign led_valid = led_valid_q;
   assign led_data  = led_valid_q ? mem_q[rd_addr] : '0;
   assign led_last  = led_valid_q & word_is_last;

   // ------------------------------------------------------------------------
   // Status read
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] status;

   always_comb begin
      status        = '0;
      status[0]     = front_q;
      status[1]     = back_full_q;
      status[2]     = overrun_q;
      status[15:8]  = 8'(angle_q);
      status[31:24] = err_cnt;
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = status;
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rresp  = RESP_OKAY;

   // ------------------------------------------------------------------------
   // Optional SLVERR counter
   // ------------------------------------------------------------------------
`ifdef POLAR_RX_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (wr_fire && !wr_ok && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         err_cnt_q <= 8'h00;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'h00;
`endif

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!resetn) begin
         aw_held_q   <= 1'b0;
         aw_addr_q   <= '0;
         w_held_q    <= 1'b0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         front_q     <= 1'b0;
         back_full_q <= 1'b0;
         overrun_q   <= 1'b0;
         // First tick after reset lands on angle 0.
         angle_q     <= ANG_W'(NO_DELTA_INTERVALS - 1);
         led_valid_q <= 1'b0;
         word_q      <= '0;
      end else begin
         aw_held_q   <= aw_held_d;
         aw_addr_q   <= aw_addr_d;
         w_held_q    <= w_held_d;
         w_data_q    <= w_data_d;
         w_strb_q    <= w_strb_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         front_q     <= front_d;
         back_full_q <= back_full_d;
         overrun_q   <= overrun_d;
         angle_q     <= angle_d;
         led_valid_q <= led_valid_d;
         word_q      <= word_d;
      end
   end

   // Read address and the unused upper offset bits carry no information.
   logic unused_bits;
   assign unused_bits = &{1'b0, s_axi_araddr, wr_off[ADDR_WIDTH-1:IDX_W+2], wr_off[1:0]};

endmodule

// File: tb/tb_polar_frame_rx.sv
// tb_polar_frame_rx
// Bench for polar_frame_rx: a frame-store model (two banks of 144 words,
// front/back_full/angle/overrun/error count) predicts write responses,
// status words and LED slices; an expected queue holds each slice's words.
module tb_polar_frame_rx;

   localparam int WPA   = 8;
   localparam int WORDS = 144;
   localparam int NDI   = 18;
   localparam int B1    = 16000;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid, s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid, s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid, s_axi_bready;
   logic [31:0] s_axi_araddr;
   logic        s_axi_arvalid, s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid, s_axi_rready;
   logic        angle_tick;
   logic [31:0] led_data;
   logic        led_valid, led_ready, led_last;

   polar_frame_rx dut (
      .clock(clock), .resetn(resetn),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready),
      .angle_tick(angle_tick), .led_data(led_data), .led_valid(led_valid),
      .led_ready(led_ready), .led_last(led_last)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- model / scoreboard ----------------
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_mem [2][WORDS];
   bit          m_front, m_full, m_ovr;
   int          m_angle, m_err;
   logic [31:0] exp_q[$];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s        = '0;
      s[0]     = m_front;
      s[1]     = m_full;
      s[2]     = m_ovr;
      s[15:8]  = 8'(m_angle);
      s[31:24] = 8'(m_err);
      return s;
   endfunction

   task automatic model_reset();
      m_front = 0; m_full = 0; m_ovr = 0; m_angle = NDI - 1; m_err = 0;
      exp_q.delete();
   endtask

   // Applies one write to the model and returns the response it must get.
   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp);
      int bank, idx;
      bit err;
      err = 0; bank = 0; idx = 0;
      if (addr % 4 != 0) err = 1;
      else if (addr < WORDS * 4) begin bank = 0; idx = int'(addr) / 4; end
      else if (addr >= B1 && addr < B1 + WORDS * 4) begin bank = 1; idx = (int'(addr) - B1) / 4; end
      else err = 1;
      if (!err && bank == int'(m_front)) err = 1;
      if (err) begin
`ifdef POLAR_RX_ERR_CNT_EN
         if (m_err < 255) m_err++;
`endif
         resp = 2'b10;
      end else begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) exp_mem[bank][idx][8*b +: 8] = data[8*b +: 8];
         if (idx == WORDS - 1) m_full = 1;
         resp = 2'b00;
      end
   endtask

   task automatic model_tick();
      m_angle = (m_angle + 1) % NDI;
      if (m_angle == 0 && m_full) begin
         m_front = ~m_front;
         m_full  = 0;
      end
      exp_q.delete();
      for (int k = 0; k < WPA; k++) exp_q.push_back(exp_mem[m_front][m_angle * WPA + k]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output bit timed_out);
      bit aw_done, w_done, aw_hs, w_hs;
      aw_done = 0; w_done = 0; timed_out = 0; resp = 2'b11;
      s_axi_awaddr = addr; s_axi_awvalid = 1;
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1;
      for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
         aw_hs = s_axi_awvalid & s_axi_awready;
         w_hs  = s_axi_wvalid & s_axi_wready;
         step();
         if (aw_hs) begin aw_done = 1; s_axi_awvalid = 0; end
         if (w_hs)  begin w_done = 1;  s_axi_wvalid = 0;  end
      end
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      for (int c = 0; c < 20 && !s_axi_bvalid; c++) step();
      if (!s_axi_bvalid) timed_out = 1;
      else begin
         resp = s_axi_bresp;
         s_axi_bready = 1;
         step();
         s_axi_bready = 0;
      end
   endtask

   task automatic axi_read(output logic [31:0] data, output logic [1:0] resp, output bit timed_out);
      bit done, hs;
      done = 0; timed_out = 0; data = '0; resp = 2'b11;
      s_axi_arvalid = 1;
      for (int c = 0; c < 20 && !done; c++) begin
         hs = s_axi_arready;
         step();
         if (hs) begin done = 1; s_axi_arvalid = 0; end
      end
      s_axi_arvalid = 0;
      for (int c = 0; c < 20 && !s_axi_rvalid; c++) step();
      if (!s_axi_rvalid) timed_out = 1;
      else begin
         data = s_axi_rdata; resp = s_axi_rresp;
         s_axi_rready = 1;
         step();
         s_axi_rready = 0;
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input string name);
      logic [1:0] resp, exp;
      bit to;
      axi_write(addr, data, strb, resp, to);
      model_write(addr, data, strb, exp);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL %s: no bvalid for addr %h (timeout)", name, addr);
      end else if (resp !== exp) begin
         failures++;
         $display("FAIL %s: addr %h bresp got %b expected %b", name, addr, resp, exp);
      end
   endtask

   task automatic do_read(input string name);
      logic [31:0] got, exp;
      logic [1:0]  rr;
      bit to;
      exp = model_status();
      axi_read(got, rr, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL %s: no rvalid (timeout)", name);
      end else if (got !== exp || rr !== 2'b00) begin
         failures++;
         $display("FAIL %s: status got %h rresp %b expected %h rresp 00", name, got, rr, exp);
      end
      if (!to) m_ovr = 0;
   endtask

   task automatic do_tick();
      angle_tick = 1;
      model_tick();
      step();
      angle_tick = 0;
   endtask

   // Called the cycle after a tick: consumes one slice and scores it.
   task automatic stream_check(input bit toggle, input bit check_data, input string name);
      int          got;
      bit          stalled;
      logic [31:0] prev_d, e;
      logic        prev_l;
      got = 0; stalled = 0; prev_d = '0; prev_l = 0;
      for (int c = 0; c < 40 && got < WPA; c++) begin
         led_ready = toggle ? (c % 2 == 0) : 1'b1;
         if (c == 0) begin
            checks++;
            if (led_valid !== 1'b1) begin
               failures++;
               $display("FAIL %s_first: led_valid got %b expected 1 one cycle after tick", name, led_valid);
            end
         end
         if (led_valid) begin
            if (stalled) begin
               checks++;
               if (led_data !== prev_d || led_last !== prev_l) begin
                  failures++;
                  $display("FAIL %s_stable: data %h last %b expected held %h %b", name, led_data, led_last, prev_d, prev_l);
               end
            end
            if (led_ready) begin
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
               if (check_data) begin
                  checks++;
                  if (led_data !== e) begin
                     failures++;
                     $display("FAIL %s_data: word %0d got %h expected %h", name, got, led_data, e);
                  end
               end
               checks++;
               if (led_last !== (got == WPA - 1)) begin
                  failures++;
                  $display("FAIL %s_last: word %0d led_last got %b expected %b", name, got, led_last, got == WPA - 1);
               end
               got++;
               stalled = 0;
            end else begin
               stalled = 1; prev_d = led_data; prev_l = led_last;
            end
         end
         step();
      end
      led_ready = 0;
      checks++;
      if (got != WPA || led_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_count: words got %0d expected %0d, led_valid after %b expected 0", name, got, WPA, led_valid);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      resetn = 0;
      s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
      s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
      angle_tick = 0; led_ready = 0;
      model_reset();
      repeat (3) step();
      resetn = 1;
      step();
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b11100) begin
         failures++;
         $display("FAIL reset_ready: aw/w/ar/b/r got %b expected 11100",
                  {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
      end
      checks++;
      if (s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00 || s_axi_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_resp: bresp %b rresp %b rdata %h expected 00 00 0", s_axi_bresp, s_axi_rresp, s_axi_rdata);
      end
      checks++;
      if (led_valid !== 1'b0 || led_last !== 1'b0 || led_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_led: valid %b last %b data %h expected 0 0 0", led_valid, led_last, led_data);
      end
      do_read("reset_status");
   endtask

   task automatic test_decode_errors();
      do_write(32'h0000_0000, $urandom, 4'hF, "front_protect_b0");
      do_write(32'h0000_0241, $urandom, 4'hF, "misaligned");
      do_write(32'h0000_8000, $urandom, 4'hF, "unmapped");
      do_write(32'h0000_40C0, $urandom, 4'hF, "past_bank1");
      do_write(32'h0000_3E82, $urandom, 4'hF, "misaligned_b1");
      do_read("err_status");
   endtask

   task automatic test_fill_swap();
      int idx;
      do_tick();
      stream_check(0, 0, "prefill_slice");
      for (int i = 0; i < WORDS; i++) begin
         do_write(32'(B1 + 4 * i), $urandom, 4'hF, "fill_b1");
         if (i == WORDS - 2) do_read("not_full_yet");
      end
      do_read("full_after_last");
      for (int i = 0; i < 4; i++) begin
         idx = $urandom_range(0, 7);
         do_write(32'(B1 + 4 * idx), $urandom, 4'($urandom_range(1, 14)), "partial_b1");
      end
      for (int t = 1; t < NDI; t++) begin
         do_tick();
         stream_check(0, 0, "b0_slice");
      end
      do_tick();
      stream_check(0, 1, "swap_slice0");
      do_read("swap_status");
   endtask

   task automatic test_front_protect();
      do_write(32'h0000_3E80, ~exp_mem[1][0], 4'hF, "front_protect_b1");
      do_write(32'h0000_0000, $urandom, 4'hF, "back_b0_ok");
      do_read("protect_status");
   endtask

   task automatic test_led_backpressure();
      do_tick();
      stream_check(1, 1, "backpressure");
   endtask

   task automatic test_overrun();
      logic [31:0] e;
      led_ready = 1;
      do_tick();
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (led_valid !== 1'b1 || led_data !== e) begin
            failures++;
            $display("FAIL ovr_first_slice: word %0d valid %b data %h expected 1 %h", k, led_valid, led_data, e);
         end
         if (k == 3) begin
            angle_tick = 1;
            model_tick();
            m_ovr = 1;
         end
         step();
      end
      angle_tick = 0;
      stream_check(0, 1, "ovr_new_slice");
      do_read("ovr_set");
      do_read("ovr_cleared");
   endtask

   task automatic test_write_order();
      logic [31:0] addr, data;
      logic [1:0]  exp;
      addr = 32'(4 * $urandom_range(1, WORDS - 2));
      data = $urandom;
      s_axi_wdata = data; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
      step();
      s_axi_wvalid = 0;
      checks++;
      if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
         failures++;
         $display("FAIL order_w_held: wready %b bvalid %b expected 0 0", s_axi_wready, s_axi_bvalid);
      end
      step(); step();
      s_axi_awaddr = addr; s_axi_awvalid = 1;
      checks++;
      if (s_axi_awready !== 1'b1) begin
         failures++;
         $display("FAIL order_awready: got %b expected 1", s_axi_awready);
      end
      step();
      s_axi_awvalid = 0;
      model_write(addr, data, 4'hF, exp);
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp) begin
         failures++;
         $display("FAIL order_bvalid: bvalid %b bresp %b expected 1 %b", s_axi_bvalid, s_axi_bresp, exp);
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
            failures++;
            $display("FAIL order_hold: cycle %0d bvalid %b awready %b wready %b expected 1 0 0",
                     c, s_axi_bvalid, s_axi_awready, s_axi_wready);
         end
         step();
      end
      s_axi_bready = 1;
      step();
      s_axi_bready = 0;
      checks++;
      if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
         failures++;
         $display("FAIL order_release: bvalid %b awready %b wready %b expected 0 1 1",
                  s_axi_bvalid, s_axi_awready, s_axi_wready);
      end
   endtask

   task automatic test_protect_unchanged();
      // Bank 0 is not full, so the wrap keeps bank 1 in front and slice 0
      // still carries the data the rejected write tried to overwrite.
      while (m_angle != 0) begin
         do_tick();
         stream_check(0, 1, "b1_rotation");
      end
      do_read("no_swap_status");
   endtask

   task automatic test_random_writes();
      logic [31:0] addr;
      for (int i = 0; i < WORDS; i++) do_write(32'(4 * i), $urandom, 4'hF, "fill_b0");
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 4))
            0, 1:    addr = 32'(4 * $urandom_range(0, WORDS - 1));
            2:       addr = 32'(B1 + 4 * $urandom_range(0, WORDS - 1));
            3:       addr = 32'(4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3));
            default: addr = $urandom_range(0, 1) ? 32'(576 + 4 * $urandom_range(0, 3000))
                                                 : 32'(16576 + 4 * $urandom_range(0, 4000));
         endcase
         do_write(addr, $urandom, 4'($urandom_range(1, 15)), "rand_write");
      end
      do_read("rand_status");
      for (int t = 0; t < NDI + 2; t++) begin
         do_tick();
         stream_check(t % 2 == 1, 1, "rand_rotation");
      end
      do_read("rand_swap_status");
   endtask

   task automatic test_reset_mid();
      logic [1:0] exp;
      logic [31:0] data;
      do_tick();
      s_axi_awaddr = 32'h0; s_axi_awvalid = 1;
      step();
      s_axi_awvalid = 0;
      resetn = 0;
      step(); step();
      resetn = 1;
      model_reset();
      step();
      checks++;
      if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || s_axi_bvalid !== 1'b0 || led_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_state: awready %b wready %b bvalid %b led_valid %b expected 1 1 0 0",
                  s_axi_awready, s_axi_wready, s_axi_bvalid, led_valid);
      end
      data = $urandom;
      s_axi_wdata = data; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
      step();
      s_axi_wvalid = 0;
      step(); step();
      checks++;
      if (s_axi_bvalid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_aw_dropped: bvalid %b expected 0", s_axi_bvalid);
      end
      s_axi_awaddr = 32'(B1 + 4); s_axi_awvalid = 1;
      step();
      s_axi_awvalid = 0;
      model_write(32'(B1 + 4), data, 4'hF, exp);
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp) begin
         failures++;
         $display("FAIL midreset_write: bvalid %b bresp %b expected 1 %b", s_axi_bvalid, s_axi_bresp, exp);
      end
      s_axi_bready = 1;
      step();
      s_axi_bready = 0;
      do_read("midreset_status");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_decode_errors();
      test_fill_swap();
      test_front_protect();
      test_led_backpressure();
      test_overrun();
      test_write_order();
      test_protect_unchanged();
      test_random_writes();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/polar_frame_rx.md
# polar_frame_rx

AXI-Lite write-side responder and double-buffered frame store for the spinning display's polar image. The Cartesian-to-polar converter's master port writes each converted frame here, alternating between bank 0 and bank 1 at `BANK_OFF`. This block takes those writes into the back bank while the front bank streams to the LED arm driver, one angle slice per `angle_tick`. A completed back bank is swapped in at the start of the next rotation.

## Interface
- `NO_ARM_LED`, 32: LEDs per arm.
- `NO_DELTA_INTERVALS`, 18: angle slices per rotation.
- `RGB_SIZE`, 8: bits per LED.
- `DATA_WIDTH`, 32: AXI and LED word width.
- `ADDR_WIDTH`, 32: AXI address width.
- `BANK_OFF`, 16000: byte offset of bank 1.
- Derived values:
  - `WPA` = `NO_ARM_LED*RGB_SIZE/DATA_WIDTH` (8), words per angle.
  - `WORDS` = `NO_DELTA_INTERVALS*WPA` (144), words per bank.
- Ports (name, direction, width, meaning):
  - `clock`, in, 1: clock.
  - `resetn`, in, 1: reset, synchronous, active-low.
  - `s_axi_awaddr`/`awvalid`/`awready`: in/in/out, `ADDR_WIDTH`/1/1. Write address channel.
  - `s_axi_wdata`/`wstrb`/`wvalid`/`wready`: in/in/in/out, `DATA_WIDTH`/4/1/1. Write data channel.
  - `s_axi_bresp`/`bvalid`/`bready`: out/out/in, 2/1/1. Write response channel.
  - `s_axi_araddr`/`arvalid`/`arready`: in/in/out, `ADDR_WIDTH`/1/1. Read address channel; the address is ignored.
  - `s_axi_rdata`/`rresp`/`rvalid`/`rready`: out/out/out/in, `DATA_WIDTH`/2/1/1. Read data channel; returns the status word.
  - `angle_tick`, in, 1: one-cycle pulse marking the next angle slice.
  - `led_data`, out, `DATA_WIDTH`: LED word.
  - `led_valid`, out, 1: `led_data` is valid.
  - `led_ready`, in, 1: LED driver accepts the word.
  - `led_last`, out, 1: marks the final word of a slice.

## Operation
- **Write capture**
  - AW and W are captured into independent one-deep holding registers, in either order or in the same cycle.
  - `awready = ~aw_held & ~bvalid`; `wready = ~w_held & ~bvalid`.
- **Address decode** (with `off` = `addr - base`):
  - Bank 0: `0 <= addr < WORDS*4`.
  - Bank 1: `BANK_OFF <= addr < BANK_OFF+WORDS*4`.
  - Word index = `off>>2`.
- **Write outcome**
  - The write is rejected if the address is outside both ranges, if `addr[1:0] != 0`, or if the target is the current front bank.
  - Rejected write: `bresp=2'b10` (SLVERR), no memory change.
  - Accepted write: byte lanes written per `wstrb`, `bresp=2'b00`.
- **Frame completion**
  - An accepted write to word `WORDS-1` of the back bank sets `back_full`.
  - Further writes to the back bank are still accepted.
- **Rotation counter**
  - `angle` counts 0..`NO_DELTA_INTERVALS-1` and advances on each `angle_tick`, wrapping to 0.
  - On a tick where `angle` becomes 0 and `back_full=1`: flip `front_bank` and clear `back_full` before streaming that slice.
- **Slice streaming**
  - Each tick streams words `angle*WPA .. angle*WPA+WPA-1` of the front bank.
  - `led_last` is asserted on word `WPA-1`.
  - A word advances only when `led_valid & led_ready`.
  - After the last word, `led_valid` drops to 0 until the next tick.
- **Overrun**
  - A tick arriving while a slice is still streaming aborts the remaining words and sets sticky `overrun`.
  - Streaming then restarts at word 0 of the new angle.
- **Status word** (returned for every read, `rresp=2'b00`):
  - `[0]` `front_bank`.
  - `[1]` `back_full`.
  - `[2]` `overrun`.
  - `[15:8]` `angle`.
  - `[31:24]` error count (see Configuration).
  - All other bits 0.
- **Overrun clear**
  - Completing a read (`rvalid & rready`) clears `overrun`.
  - If an overrun occurs in the same cycle, set wins.

## Timing
- **Reset values**
  - Outputs: `awready=1`, `wready=1`, `arready=1`, `bvalid=0`, `rvalid=0`, `bresp=0`, `rresp=0`, `rdata=0`, `led_valid=0`, `led_last=0`, `led_data=0`.
  - Internal state: `front_bank=0`, `back_full=0`, `overrun=0`, `angle=NO_DELTA_INTERVALS-1`, so the first tick selects angle 0.
  - Memory is not reset.
- **Write response**
  - If both AW and W are held at the end of cycle N, the memory update and `bvalid=1` occur in cycle N+1.
  - `bvalid` holds until `bready`; the ready signals reopen the cycle after the `bvalid & bready` handshake.
- **Read response**
  - `arvalid & arready` at cycle N gives `rvalid=1` at N+1, holding until `rready`.
  - `arready = ~rvalid`.
  - The status word is sampled at N.
- **LED stream**
  - A tick at cycle T gives the first word at T+1.
  - Throughput is one word per cycle while `led_ready` is held high.
  - `led_data` and `led_last` are stable while `led_valid & ~led_ready`.
- **Swap visibility**
  - A bank swap at tick T takes effect on the word presented at T+1.
  - It affects AXI decode from cycle T+1.
- **Reset mid-operation**
  - Reset drops all pending AW/W, B and R state with no response.
  - Reset aborts the current slice.

## Configuration
- `POLAR_RX_ERR_CNT_EN`
  - Defined: an 8-bit error counter increments on every SLVERR response, saturates at 255, resets to 0, and is reported in status `[31:24]`.
  - Undefined: no counter is built and status `[31:24]` reads 0.

## Test plan
- **Fill bank 1 and swap:** write 144 words to bank 1 (`0x3E80`..`0x40BC`), then 18 ticks.
  - All writes return `bresp=0`; `back_full=1` after word 143.
  - The 18th tick (angle wraps to 0) sets `front_bank=1` and `back_full=0`.
  - Slice 0 then streams the values written to words 0..7.
- **Front-bank protection:** write address `0x0` while bank 0 is front.
  - `bresp=2'b10` and memory is unchanged.
  - With the macro defined, the status read shows `[31:24]=1`.
- **Decode errors:** write address `0x241` (misaligned) and address `0x8000` (unmapped).
  - Both return SLVERR with no write.
- **Write handshake order:** W presented 3 cycles before AW.
  - `wready` drops after W is captured; `bvalid` rises the cycle after AW is captured.
  - Holding `bready=0` for 5 cycles keeps `bvalid` high and both readies at 0.
- **LED backpressure:** tick with `led_ready` toggling 1,0,1,…
  - Exactly 8 words are delivered in order with `led_last` on the 8th.
  - Data is stable while not ready.
- **Overrun:** tick, then a second tick 4 cycles later with `led_ready=1`.
  - The first slice stops at 4 words and the new slice starts at word 0.
  - Status `[2]=1`; a second status read returns `[2]=0`.
